// File: rtl/jtopl_out_pkg.sv
// Shared constants, pipeline stage types and the output saturation helper
// for the OPL sound output stage.
package jtopl_out_pkg;

  localparam logic [4:0]         GAIN_UNITY = 5'd8;
  localparam int                 GAIN_FRAC  = 3;
  localparam logic signed [15:0] SND_MAX    = 16'sh7FFF;
  localparam logic signed [15:0] SND_MIN    = 16'sh8000;

  localparam logic signed [21:0] LIM_HI = 22'sd32767;
  localparam logic signed [21:0] LIM_LO = -22'sd32768;

  // Captured input word, held until the next capture event.
  typedef struct packed {
    logic               v;
    logic signed [15:0] snd;
    logic [4:0]         gain;
  } cap_t;

  // Gain product, wide enough for -32768 * 31.
  typedef struct packed {
    logic               v;
    logic signed [21:0] prod;
  } prod_t;

  function automatic logic signed [15:0] sat16(input logic signed [21:0] x);
    logic signed [15:0] r;
    if (x > LIM_HI) begin
      r = SND_MAX;
    end else if (x < LIM_LO) begin
      r = SND_MIN;
    end else begin
      r = x[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/jtopl_snd_fifo.sv
// Small circular sample FIFO with a registered head word, so the sink sees the
// new head on the same edge as a pop and a stable value while empty.
module jtopl_snd_fifo
  import jtopl_out_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic signed [15:0] din,
  input  logic               rd_ready,
  output logic               valid,
  output logic signed [15:0] head,
  output logic [AW:0]        level,
  output logic               drop
);

  logic signed [15:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic signed [15:0] head_q, head_d;
  logic               full, empty, pop_en, wr_en;
  logic [AW:0]        remaining;

  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop_en = !empty && rd_ready;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign wr_en  = push && (!full || pop_en);
  assign drop   = push && full && !pop_en;

  assign remaining = count_q - (AW+1)'(pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop_en);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop_en);
    head_d   = head_q;
    if (wr_en && remaining == '0) begin
      head_d = din;
    end else if (remaining != '0) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (wr_en && wr_ptr_q == AW'(gi)) begin
          mem_q[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign valid = !empty;
  assign head  = head_q;
  assign level = count_q;

endmodule

// File: rtl/jtopl_snd_out.sv
// OPL output stage: captures the accumulator word on each sample strobe,
// applies a saturating Q2.3 master gain and queues results for the sink.
module jtopl_snd_out
  import jtopl_out_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cenop,
  input  logic               sample,
  input  logic signed [15:0] snd_in,
  input  logic [4:0]         gain,
  input  logic               out_ready,
  output logic               out_valid,
  output logic signed [15:0] out_snd,
  output logic [AW:0]        level,
  output logic               ovf,
  input  logic               ovf_clr
);

  cap_t               cap_q, cap_d;
  prod_t              prd_q, prd_d;
  logic               ovf_q, ovf_d;
  logic signed [21:0] scaled;
  logic signed [15:0] sat_word;
  logic               fifo_drop;

  always_comb begin
    cap_d   = cap_q;
    cap_d.v = cenop && sample;
    if (cenop && sample) begin
      cap_d.snd  = snd_in;
      cap_d.gain = gain;
    end
  end

  always_comb begin
    prd_d.v    = cap_q.v;
    prd_d.prod = $signed({{6{cap_q.snd[15]}}, cap_q.snd}) * $signed({17'd0, cap_q.gain});
  end

  // Arithmetic shift floors toward -inf, matching the OPL DAC rounding.
  assign scaled   = prd_q.prod >>> GAIN_FRAC;
  assign sat_word = sat16(scaled);

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
      prd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      prd_q <= prd_d;
      ovf_q <= ovf_d;
    end
  end

  jtopl_snd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (prd_q.v),
    .din      (sat_word),
    .rd_ready (out_ready),
    .valid    (out_valid),
    .head     (out_snd),
    .level    (level),
    .drop     (fifo_drop)
  );

  assign ovf = ovf_q;

endmodule

// File: doc/jtopl_snd_out.md
Name: jtopl_snd_out

Overview:
- Output stage directly downstream of the operator accumulator.
- Samples the accumulator's continuous signed 16-bit sound word once per output sample period and applies a saturating master gain.
- Buffers results in a small FIFO and presents them to an audio sink (I2S/PWM/DAC serializer) over a valid/ready handshake.
- Decouples the OPL sample cadence from the sink's own timing.

Parameters:
- DEPTH, 4, FIFO depth in samples; power of two, 2..16.
- AW, 2, FIFO address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cenop  in  1  operator clock enable; the sample strobe is qualified by it.
- sample  in  1  end-of-sample strobe from the timing block, valid only when cenop=1.
- snd_in  in  16  signed accumulated sound from the accumulator.
- gain  in  5  unsigned master gain, Q2.3 format; 8 = unity, 0 = mute.
- out_ready  in  1  sink accepts the current word.
- out_valid  out  1  FIFO head word valid.
- out_snd  out  16  signed FIFO head word.
- level  out  AW+1  FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (async, active-high): all of the following clear immediately, regardless of clk:
  - out_valid=0, out_snd=0, level=0, ovf=0;
  - pipeline valid bits, pointers and FIFO contents.
- Capture:
  - A capture event is cenop && sample in cycle N.
  - snd_in and gain are registered at the edge ending cycle N.
  - Other cycles ignore snd_in.
- Stage 1 (edge ending N+1):
  - prod = snd_in * {1'b0,gain}, a 22-bit signed product, registered with valid bit v1.
- Stage 2 (edge ending N+2):
  - scaled = prod >>> 3 (arithmetic shift, rounds toward -inf).
  - Saturate to 16 bits: >32767 gives 32767; <-32768 gives -32768.
  - Push into the FIFO if v2.
- Latency:
  - With the FIFO empty, out_valid rises in cycle N+3, i.e. after the edge ending N+2.
  - No bypass path.
- Back-to-back captures are allowed every cycle; the pipeline is fully pipelined.
- Handshake:
  - A pop occurs on any edge with out_valid && out_ready.
  - out_snd and out_valid update on the same edge.
  - out_snd always reflects the head word; it holds its last value when empty but must not be consumed.
  - out_valid may not drop without a pop.
- FIFO:
  - Circular buffer; read and write pointers are AW bits and wrap DEPTH-1 to 0.
  - level = number of stored words.
- Full, with push and no pop: the new sample is dropped, ovf is set, and contents are unchanged.
- Full, with push and pop on the same edge: the push is accepted, level stays DEPTH, and ovf is unchanged.
- Empty, with push and out_ready=1: no pop that cycle, because out_valid=0.
- ovf:
  - Set on any dropped push.
  - ovf_clr clears it.
  - Same-edge set and clear: set wins.
- gain=0: produces zeros. These are still pushed, so the cadence is preserved.
- gain or snd_in changing between captures has no effect.

Decomposition:
- Package jtopl_out_pkg holds:
  - GAIN_UNITY=5'd8, GAIN_FRAC=3;
  - SND_MAX=16'sd32767, SND_MIN=-16'sd32768;
  - the saturation function sat16.
- One sub-module, jtopl_snd_fifo: parameterised DEPTH/AW storage, pointers, level, push/pop with full/empty logic.
- The gain pipeline, saturation and ovf flag stay in the top module.

Test Plan:
- Unity, single sample: gain=8, snd_in=16'sh1234, capture in cycle 0 → out_valid=1 from cycle 3, out_snd=0x1234; out_ready=1 → out_valid=0, level=0 next cycle.
- Saturation:
  - gain=31, snd_in=20000 → 32767.
  - gain=31, snd_in=-20000 → -32768.
  - gain=4, snd_in=-3 → -2 (floor of -1.5).
  - gain=0, snd_in=-32768 → 0.
- Overflow: DEPTH=4, out_ready=0, six captures of values 1..6 →
  - level=4, ovf=1, FIFO pops 1,2,3,4;
  - ovf_clr → ovf=0.
- Full with simultaneous push and pop: FIFO holds 1..4; a capture of 5 lands on the same edge as a pop → level stays 4, ovf=0, pop order 2,3,4,5.
- Cadence and wrap: capture every cycle for 40 cycles with out_ready=1 and values 0..39 → output sequence identical, no ovf, pointers wrap ≥9 times.
- Reset mid-operation: 3 words queued plus 2 in the pipeline; assert rst between clock edges → out_valid, level and ovf are 0 immediately; after release, no stale words ever appear.
